// File: rtl/kv_line_mem.sv
// kv_line_mem: line-granular backing memory. It answers line fetches after a fixed
// latency and absorbs whole-line write-backs. The array itself is never reset.
module kv_line_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_SIZE    = 4,
  parameter int MEM_LINES    = 1024,
  parameter int READ_LATENCY = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic [ADDR_WIDTH-1:0]                i_req_addr,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] o_resp_data,
  output logic                                 o_resp_valid,
  input  logic                                 i_resp_ready,
  input  logic [ADDR_WIDTH-1:0]                i_wb_addr,
  input  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] i_wb_data,
  input  logic                                 i_wb_valid,
  output logic                                 o_wb_ready
);

  localparam int OFS  = $clog2(DATA_WIDTH/8) + $clog2(LINE_SIZE);
  localparam int IDXW = $clog2(MEM_LINES);
  localparam int CW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                               state, nxt;
  logic [CW-1:0]                        cnt;
  logic [IDXW-1:0]                      lat_idx;
  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] mem [MEM_LINES];

  // Offset and upper address bits are deliberately dropped: lines alias modulo MEM_LINES.
  logic [IDXW-1:0] req_idx, wb_idx;
  logic            unused_addr;
  assign req_idx     = i_req_addr[OFS +: IDXW];
  assign wb_idx      = i_wb_addr[OFS +: IDXW];
  assign unused_addr = &{i_req_addr, i_wb_addr};

  logic fire_req, fire_wb, cnt_done;
  assign fire_req = i_req_valid & o_req_ready;
  assign fire_wb  = i_wb_valid & o_wb_ready;
  assign cnt_done = (cnt == '0);

  // State register; a reset drops any fetch in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (fire_req)     nxt = S_WAIT;
      S_WAIT:  if (cnt_done)     nxt = S_RESP;
      S_RESP:  if (i_resp_ready) nxt = S_IDLE;
      default:                   nxt = S_IDLE;
    endcase
  end

  // Outputs: write-back wins over fetch, and nothing is accepted while busy or in reset.
  always_comb begin
    o_wb_ready   = (state == S_IDLE) & i_rstn;
    o_req_ready  = (state == S_IDLE) & ~i_wb_valid & i_rstn;
    o_resp_valid = (state == S_RESP);
  end

  // Latency counter, latched line index and registered response line.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt         <= '0;
      lat_idx     <= '0;
      o_resp_data <= '0;
    end else begin
      if (fire_req) begin
        cnt     <= CW'(READ_LATENCY - 1);
        lat_idx <= req_idx;
      end else if (state == S_WAIT) begin
        if (cnt_done) o_resp_data <= mem[lat_idx];
        else          cnt         <= cnt - CW'(1);
      end
    end
  end

  // Line array; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (fire_wb) mem[wb_idx] <= i_wb_data;
  end

endmodule

// File: tb/tb_kv_line_mem.sv
// Bench for kv_line_mem: two instances (latency 4 and latency 1) checked against
// a line-array reference model indexed by plain address arithmetic.
module tb_kv_line_mem;
  localparam int DW = 32, AW = 32, LS = 4, ML = 1024;
  typedef logic [LS-1:0][DW-1:0] line_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn [2];
  logic [AW-1:0] req_addr [2], wb_addr [2];
  logic          req_valid [2], req_ready [2], resp_valid [2], resp_ready [2];
  logic          wb_valid [2], wb_ready [2];
  line_t         resp_data [2], wb_data [2];

  kv_line_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS), .MEM_LINES(ML), .READ_LATENCY(4)) u0 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_req_addr(req_addr[0]), .i_req_valid(req_valid[0]),
    .o_req_ready(req_ready[0]), .o_resp_data(resp_data[0]), .o_resp_valid(resp_valid[0]),
    .i_resp_ready(resp_ready[0]), .i_wb_addr(wb_addr[0]), .i_wb_data(wb_data[0]),
    .i_wb_valid(wb_valid[0]), .o_wb_ready(wb_ready[0]));

  kv_line_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS), .MEM_LINES(ML), .READ_LATENCY(1)) u1 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_req_addr(req_addr[1]), .i_req_valid(req_valid[1]),
    .o_req_ready(req_ready[1]), .o_resp_data(resp_data[1]), .o_resp_valid(resp_valid[1]),
    .i_resp_ready(resp_ready[1]), .i_wb_addr(wb_addr[1]), .i_wb_data(wb_data[1]),
    .i_wb_valid(wb_valid[1]), .o_wb_ready(wb_ready[1]));

  // Reference model: one line per index, plus a written flag so fetches avoid X lines.
  line_t model   [2][ML];
  bit    written [2][ML];

  int compared = 0, mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rl(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int lidx(input logic [AW-1:0] a);
    return int'((a / 16) % ML);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_wb(input int d, input logic [AW-1:0] a, input line_t l);
    wb_addr[d] = a; wb_data[d] = l; wb_valid[d] = 1'b1;
    #1 chk("wb_ready", 128'(wb_ready[d]), 128'(1));
    tick;
    wb_valid[d] = 1'b0;
    model[d][lidx(a)] = l;
    written[d][lidx(a)] = 1'b1;
  endtask

  // Fetch a line, hold the response for 'stall' cycles, then consume it.
  task automatic do_fetch(input int d, input logic [AW-1:0] a, input int stall, output int acc_cyc);
    line_t exp = model[d][lidx(a)];
    int n = 0;
    req_addr[d] = a; req_valid[d] = 1'b1;
    #1;
    while (req_ready[d] !== 1'b1 && n < 20) begin tick; n++; end
    chk("accept_tmo", 128'(n < 20), 128'(1));
    acc_cyc = cyc;
    tick;
    req_valid[d] = 1'b0;
    #1;
    chk("busy_req_ready", 128'(req_ready[d]), 128'(0));
    chk("busy_wb_ready", 128'(wb_ready[d]), 128'(0));
    chk("early_valid", 128'(resp_valid[d]), 128'(0));
    n = 0;
    while (n < 30) begin
      tick; n++;
      if (resp_valid[d] === 1'b1) break;
    end
    chk("latency", 128'(n), 128'(rl(d)));
    chk("resp_data", resp_data[d], exp);
    repeat (stall) begin
      tick;
      chk("stall_valid", 128'(resp_valid[d]), 128'(1));
      chk("stall_data", resp_data[d], exp);
      chk("stall_readies", 128'({req_ready[d], wb_ready[d]}), 128'(0));
    end
    resp_ready[d] = 1'b1;
    tick;
    resp_ready[d] = 1'b0;
    #1;
    chk("post_valid", 128'(resp_valid[d]), 128'(0));
    chk("post_readies", 128'({req_ready[d], wb_ready[d]}), 128'(2'b11));
  endtask

  function automatic line_t rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev, c0;
    line_t l1, la;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; req_addr[d] = '0; wb_addr[d] = '0; wb_data[d] = '0;
      req_valid[d] = 1'b0; resp_ready[d] = 1'b0; wb_valid[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) for (int i = 0; i < ML; i++) written[d][i] = 1'b0;

    // Reset state
    repeat (2) tick;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 128'(resp_valid[d]), 128'(0));
      chk("rst_data", resp_data[d], 128'(0));
      chk("rst_readies", 128'({req_ready[d], wb_ready[d]}), 128'(0));
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    #1 chk("idle_readies", 128'({req_ready[0], wb_ready[0]}), 128'(2'b11));
    tick;

    // 1: write-back then fetch, latency 4
    l1 = {32'h0505_0505, 32'h5555_5555, 32'h5555_0000, 32'h0000_5555};
    do_wb(0, 32'h1000_1000, l1);
    do_fetch(0, 32'h1000_1000, 0, acc);
    chk("t1_word0", 128'(resp_data[0][0]), 128'(32'h0000_5555));
    chk("t1_word3", 128'(resp_data[0][3]), 128'(32'h0505_0505));

    // 2: response held 5 cycles
    do_fetch(0, 32'h1000_1000, 5, acc);

    // 3: write-back and fetch valid together
    la = {4{32'hAAAA_AAAA}};
    wb_addr[0] = 32'h1000_1000; wb_data[0] = la; wb_valid[0] = 1'b1;
    req_addr[0] = 32'h1000_1000; req_valid[0] = 1'b1;
    #1;
    chk("t3_req_ready", 128'(req_ready[0]), 128'(0));
    chk("t3_wb_ready", 128'(wb_ready[0]), 128'(1));
    c0 = cyc;
    tick;
    wb_valid[0] = 1'b0;
    model[0][lidx(32'h1000_1000)] = la;
    do_fetch(0, 32'h1000_1000, 0, acc);
    chk("t3_next_accept", 128'(acc - c0), 128'(1));
    chk("t3_data", resp_data[0], la);

    // 4: offset and upper bits alias onto the same line
    do_fetch(0, 32'h1000_100C, 1, acc);
    do_fetch(0, 32'h1000_5000, 0, acc);

    // 5: reset during WAIT drops the fetch, keeps the array
    req_addr[0] = 32'h1000_1000; req_valid[0] = 1'b1;
    tick;
    req_valid[0] = 1'b0;
    tick;
    rstn[0] = 1'b0;
    #1;
    chk("t5_valid", 128'(resp_valid[0]), 128'(0));
    chk("t5_readies", 128'({req_ready[0], wb_ready[0]}), 128'(0));
    repeat (2) tick;
    rstn[0] = 1'b1;
    #1 chk("t5_readies_rel", 128'({req_ready[0], wb_ready[0]}), 128'(2'b11));
    repeat (6) begin
      tick;
      chk("t5_no_resp", 128'(resp_valid[0]), 128'(0));
    end
    do_fetch(0, 32'h1000_1000, 0, acc);
    chk("t5_preserved", resp_data[0], la);

    // 6: latency 1, eight back-to-back fetches to distinct lines
    for (int i = 0; i < 8; i++) do_wb(1, 32'h2000_0000 + 32'(i * 16), rnd_line());
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      do_fetch(1, 32'h2000_0000 + 32'(i * 16), 0, acc);
      if (i > 0) chk("t6_period", 128'(acc - prev), 128'(3));
      prev = acc;
    end

    // Randomized mix of write-backs and fetches on both instances
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 60; k++) begin
        int idx = $urandom_range(0, 7) * 131 % ML;
        logic [AW-1:0] a = ($urandom & 32'hFFFF_C00F) | AW'(idx << 4);
        if (!written[d][idx] || $urandom_range(0, 2) == 0) do_wb(d, a, rnd_line());
        else do_fetch(d, a, $urandom_range(0, 3), acc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
